// File: rtl/addsub_accumulator.sv
// addsub_accumulator: folds a stream of add/subtract beats into an N-bit
// running accumulator and presents the batch result on a valid/ready port.
module addsub_accumulator #(
  parameter int N       = 4,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       operand,
  input  logic               CTRL,
  input  logic               last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       acc,
  output logic               cout,
  output logic               ovf,
  output logic [COUNT_W-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         acc_q, acc_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 out_valid_q, out_valid_d;

  logic [N-1:0]         opb;
  logic [N:0]           sum;
  logic                 ovf_step;
  logic [COUNT_W-1:0]   count_inc;
  logic                 accept;

  assign in_ready  = (state_q != S_DONE);
  assign accept    = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

  // Datapath: N+1-bit add of accumulator and (possibly inverted) operand, plus
  // signed-overflow detect and saturating beat count.
  always_comb begin
    opb       = CTRL ? ~operand : operand;
    sum       = {1'b0, acc_q} + {1'b0, opb} + {{N{1'b0}}, CTRL};
    ovf_step  = (acc_q[N-1] == opb[N-1]) && (sum[N-1] != acc_q[N-1]);
    count_inc = (count_q == {COUNT_W{1'b1}}) ? count_q : count_q + COUNT_W'(1);
  end

  // Next-state and next-register computation; registers hold unless updated.
  // Accumulator state is already zero whenever IDLE is entered, so IDLE and
  // ACCUM share the same fold path.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          acc_d   = sum[N-1:0];
          cout_d  = sum[N];
          ovf_d   = ovf_q | ovf_step;
          count_d = count_inc;
          state_d = last ? S_DONE : S_ACCUM;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    out_valid_d = (state_d == S_DONE);
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator with hand-computed expectations.
module tb_addsub_accumulator;

  localparam int N       = 4;
  localparam int COUNT_W = 4;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       operand;
  logic               CTRL;
  logic               last;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       acc;
  logic               cout;
  logic               ovf;
  logic [COUNT_W-1:0] count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  addsub_accumulator #(.N(N), .COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand   (operand),
    .CTRL      (CTRL),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .cout      (cout),
    .ovf       (ovf),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat for exactly one clock edge; returns 1 time unit after it.
  task automatic send_beat(input logic [N-1:0] op, input logic sub, input logic lst,
                           input logic ordy);
    in_valid  = 1'b1;
    operand   = op;
    CTRL      = sub;
    last      = lst;
    out_ready = ordy;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    last      = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] e_acc, input logic e_c,
                              input logic e_v, input logic [COUNT_W-1:0] e_cnt);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".acc"},   32'(acc),       32'(e_acc));
    check({tag, ".cout"},  32'(cout),      32'(e_c));
    check({tag, ".ovf"},   32'(ovf),       32'(e_v));
    check({tag, ".count"}, 32'(count),     32'(e_cnt));
  endtask

  // Consume the pending result and confirm the block is back to a cleared IDLE.
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".hs_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".hs_acc"},   32'(acc),       32'd0);
    check({tag, ".hs_count"}, 32'(count),     32'd0);
    check({tag, ".hs_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    operand   = '0;
    CTRL      = 1'b0;
    last      = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst.acc",   32'(acc),       32'd0);
    check("rst.cout",  32'(cout),      32'd0);
    check("rst.ovf",   32'(ovf),       32'd0);
    check("rst.count", 32'(count),     32'd0);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.ready", 32'(in_ready),  32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single beat, then backpressure in DONE with in_valid pulsing.
    send_beat(4'd2, 1'b0, 1'b1, 1'b0);
    check_result("single", 4'd2, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      operand  = 4'd5;
      check("bp.ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check_result("bp", 4'd2, 1'b0, 1'b0, 4'd1);
    end
    in_valid = 1'b0;
    handshake("bp");
    send_beat(4'd3, 1'b0, 1'b1, 1'b0);
    check_result("second", 4'd3, 1'b0, 1'b0, 4'd1);
    handshake("second");

    // Mixed add/sub; out_ready during ACCUM must have no effect.
    send_beat(4'd4, 1'b0, 1'b0, 1'b0);
    check("mixed.mid_valid", 32'(out_valid), 32'd0);
    check("mixed.mid_acc",   32'(acc),       32'd4);
    send_beat(4'd5, 1'b1, 1'b1, 1'b1);
    check_result("mixed", 4'hF, 1'b0, 1'b0, 4'd2);
    handshake("mixed");

    // Positive overflow: 7 + 2.
    send_beat(4'd7, 1'b0, 1'b0, 1'b0);
    send_beat(4'd2, 1'b0, 1'b1, 1'b0);
    check_result("povf", 4'd9, 1'b0, 1'b1, 4'd2);
    handshake("povf");

    // Negative overflow: -8 - 3.
    send_beat(4'd8, 1'b0, 1'b0, 1'b0);
    send_beat(4'd3, 1'b1, 1'b1, 1'b0);
    check_result("novf", 4'd5, 1'b1, 1'b1, 4'd2);
    handshake("novf");

    // Asynchronous reset mid-batch.
    send_beat(4'd5, 1'b0, 1'b0, 1'b0);
    send_beat(4'd1, 1'b0, 1'b0, 1'b0);
    check("rmid.pre_acc", 32'(acc), 32'd6);
    #2 rst = 1'b1;
    #1;
    check("rmid.acc",   32'(acc),       32'd0);
    check("rmid.count", 32'(count),     32'd0);
    check("rmid.valid", 32'(out_valid), 32'd0);
    #1 rst = 1'b0;
    send_beat(4'd6, 1'b0, 1'b1, 1'b0);
    check_result("rmid_next", 4'd6, 1'b0, 1'b0, 4'd1);
    handshake("rmid_next");

    // Count saturation: 17 beats of +1; 7+1 sets the sticky overflow.
    for (int i = 0; i < 17; i++) begin
      send_beat(4'd1, 1'b0, (i == 16), 1'b0);
    end
    check_result("sat", 4'd1, 1'b0, 1'b1, 4'd15);
    handshake("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
